float_to_int: RTL and testbench

//  Downstream stage of the single-precision FP adder. Consumes its IEEE-754 FP32 result over the
//  stb/ack handshake and converts it to a 32-bit two's-complement signed integer.
//  The default conversion truncates toward zero. Uses the same stb/ack protocol on both sides, so
//  it chains directly after the adder or any other FP32 producer in the FPU.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/float_to_int.sv | 135 +++++++++++++
 tb/tb_float_to_int.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP32 constants and FSM state encoding for the FPU stages
package fpu_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int FRAC_W   = 23;

  localparam logic [31:0] INDEFINITE_DEFAULT = 32'h8000_0000;

  typedef enum logic [3:0] {
    get_a         = 4'd0,
    unpack        = 4'd1,
    special_cases = 4'd2,
    convert       = 4'd3,
    round         = 4'd4,
    pack          = 4'd5,
    put_z         = 4'd6
  } fpu_state_t;

endpackage

// File: rtl/float_to_int.sv
// rtl/float_to_int.sv - FP32 to signed int32 converter with stb/ack handshake (FLOAT_TO_INT_ROUND_EN selects round-to-nearest-even)
module float_to_int
  import fpu_pkg::*;
#(
  parameter logic [31:0] INDEFINITE = INDEFINITE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam logic [7:0]        EXP_ALL_ONES = 8'(EXP_MAX);
  localparam logic [9:0]        BIAS_10      = 10'(EXP_BIAS);
  localparam logic signed [9:0] E_TOP        = 10'sd31;

`ifdef FLOAT_TO_INT_ROUND_EN
  // One extra exponent step (e==-1) can still round up to 1
  localparam logic signed [9:0] E_MIN = -10'sd1;
`else
  localparam logic signed [9:0] E_MIN = 10'sd0;
`endif

  fpu_state_t        state;
  logic [31:0]       a;
  logic [31:0]       m;
  logic signed [9:0] e;
  logic              s;
  logic [31:0]       z;
`ifdef FLOAT_TO_INT_ROUND_EN
  logic              guard;
  logic              sticky;
`endif

  // Main conversion FSM: handshake, unpack, range checks, serial shift, sign apply
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= get_a;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= 32'h0;
      a            <= 32'h0;
      m            <= 32'h0;
      e            <= 10'sd0;
      s            <= 1'b0;
      z            <= 32'h0;
`ifdef FLOAT_TO_INT_ROUND_EN
      guard        <= 1'b0;
      sticky       <= 1'b0;
`endif
    end else begin
      case (state)
        get_a: begin
          if (input_a_ack && input_a_stb) begin
            a           <= input_a;
            input_a_ack <= 1'b0;
            state       <= unpack;
          end else begin
            input_a_ack <= 1'b1;
          end
        end

        unpack: begin
          m     <= {1'b1, a[FRAC_W-1:0], 8'b0};
          e     <= $signed({2'b00, a[30:23]} - BIAS_10);
          s     <= a[31];
`ifdef FLOAT_TO_INT_ROUND_EN
          guard  <= 1'b0;
          sticky <= 1'b0;
`endif
          state <= special_cases;
        end

        special_cases: begin
          if (a[30:23] == EXP_ALL_ONES) begin
            z     <= INDEFINITE;
            state <= put_z;
          end else if (a[30:23] == 8'd0) begin
            z     <= 32'h0;
            state <= put_z;
          end else if (e >= E_TOP) begin
            z     <= INDEFINITE;
            state <= put_z;
          end else if (e < E_MIN) begin
            z     <= 32'h0;
            state <= put_z;
          end else begin
            state <= convert;
          end
        end

        convert: begin
          // Integer part settles at bit 0 once e reaches 31
          m <= m >> 1;
          e <= e + 10'sd1;
`ifdef FLOAT_TO_INT_ROUND_EN
          guard  <= m[0];
          sticky <= sticky | guard;
          if (e == E_TOP - 10'sd1) state <= round;
`else
          if (e == E_TOP - 10'sd1) state <= pack;
`endif
        end

`ifdef FLOAT_TO_INT_ROUND_EN
        round: begin
          if (guard && (sticky || m[0])) m <= m + 32'd1;
          state <= pack;
        end
`endif

        pack: begin
          z     <= s ? -m : m;
          state <= put_z;
        end

        put_z: begin
          output_z_stb <= 1'b1;
          output_z     <= z;
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            state        <= get_a;
          end
        end

        default: state <= get_a;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// tb/tb_float_to_int.sv - directed self-checking bench for float_to_int
module tb_float_to_int;

`ifdef FLOAT_TO_INT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] input_a = 32'h0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  bit mon_en = 1'b0;
  int in_cnt = 0;
  int out_cnt = 0;
  int bad_out = 0;

  float_to_int dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  // Count handshakes at negedge: values seen here are those present at the next rising edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (input_a_stb && input_a_ack) in_cnt++;
      if (output_z_stb && output_z_ack) begin
        out_cnt++;
        if (output_z !== 32'h7FFF_FF80) bad_out++;
      end
    end
  end

  // Sends one operand, returns latency (edges from accept to stb) and result; leaves stb pending
  task automatic send_and_wait(input logic [31:0] val, output int lat, output logic [31:0] res);
    int n;
    input_a      = val;
    input_a_stb  = 1'b1;
    n = 0;
    while (!input_a_ack && n < 100) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (!input_a_ack) begin
      bad++;
      $display("FAIL accept_timeout a=%h ack=%b required=1", val, input_a_ack);
    end
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    lat = 0;
    while (!output_z_stb && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    res = output_z;
  endtask

  task automatic take_output();
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (input_a_ack !== 1'b0 || output_z_stb !== 1'b0 || output_z !== 32'h0) begin
      bad++;
      $display("FAIL reset_state ack=%b stb=%b z=%h required ack=0 stb=0 z=0",
               input_a_ack, output_z_stb, output_z);
    end
    rst = 1'b1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] z_t;
    logic [31:0] z_r;
    int          lat_t;
    int          lat_r;
  } vec_t;

  task automatic test_convert();
    vec_t v[12];
    int lat;
    logic [31:0] res;
    logic [31:0] exp_z;
    int exp_lat;
    v[0]  = '{32'h3F80_0000, 32'h0000_0001, 32'h0000_0001, 35, 36};
    v[1]  = '{32'hC2F6_0000, 32'hFFFF_FF85, 32'hFFFF_FF85, 29, 30};
    v[2]  = '{32'hC020_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 34, 35};
    v[3]  = '{32'h4060_0000, 32'h0000_0003, 32'h0000_0004, 34, 35};
    v[4]  = '{32'h3F00_0000, 32'h0000_0000, 32'h0000_0000, 3, 37};
    v[5]  = '{32'h7FC0_0000, 32'h8000_0000, 32'h8000_0000, 3, 3};
    v[6]  = '{32'hFF80_0000, 32'h8000_0000, 32'h8000_0000, 3, 3};
    v[7]  = '{32'h4F00_0000, 32'h8000_0000, 32'h8000_0000, 3, 3};
    v[8]  = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 3, 3};
    v[9]  = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 3, 3};
    v[10] = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 32'h7FFF_FF80, 5, 6};
    v[11] = '{32'hCF00_0000, 32'h8000_0000, 32'h8000_0000, 3, 3};
    for (int i = 0; i < 12; i++) begin
      exp_z   = RND ? v[i].z_r : v[i].z_t;
      exp_lat = RND ? v[i].lat_r : v[i].lat_t;
      send_and_wait(v[i].a, lat, res);
      total++;
      if (res !== exp_z) begin
        bad++;
        $display("FAIL value a=%h got=%h required=%h", v[i].a, res, exp_z);
      end
      total++;
      if (lat != exp_lat) begin
        bad++;
        $display("FAIL latency a=%h got=%0d required=%0d", v[i].a, lat, exp_lat);
      end
      take_output();
      total++;
      if (output_z_stb !== 1'b0) begin
        bad++;
        $display("FAIL stb_drop a=%h stb=%b required=0", v[i].a, output_z_stb);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] res;
    send_and_wait(32'hC2F6_0000, lat, res);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (output_z_stb !== 1'b1 || output_z !== 32'hFFFF_FF85 || input_a_ack !== 1'b0) begin
        bad++;
        $display("FAIL backpressure cyc=%0d stb=%b z=%h ack=%b required stb=1 z=ffffff85 ack=0",
                 i, output_z_stb, output_z, input_a_ack);
      end
    end
    take_output();
    total++;
    if (output_z_stb !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_release stb=%b required=0", output_z_stb);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    in_cnt = 0; out_cnt = 0; bad_out = 0;
    input_a      = 32'h4EFF_FFFF;
    input_a_stb  = 1'b1;
    output_z_ack = 1'b1;
    mon_en       = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    input_a_stb = 1'b0;
    n = 0;
    repeat (30) @(posedge clk);
    #1;
    mon_en = 1'b0;
    output_z_ack = 1'b0;
    total++;
    if (in_cnt != out_cnt || in_cnt < 3) begin
      bad++;
      $display("FAIL b2b_count in=%0d out=%0d required equal and >=3", in_cnt, out_cnt);
    end
    total++;
    if (bad_out != 0) begin
      bad++;
      $display("FAIL b2b_values wrong=%0d required=0", bad_out);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int lat;
    logic [31:0] res;
    input_a     = 32'h3F80_0000;
    input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    output_z_ack = 1'b1;
    #2 rst = 1'b0;
    #1;
    total++;
    if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0 || output_z !== 32'h0) begin
      bad++;
      $display("FAIL async_reset stb=%b ack=%b z=%h required stb=0 ack=0 z=0",
               output_z_stb, input_a_ack, output_z);
    end
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    rst = 1'b1;
    send_and_wait(32'h3F80_0000, lat, res);
    total++;
    if (res !== 32'h0000_0001 || output_z_stb !== 1'b1) begin
      bad++;
      $display("FAIL after_reset z=%h stb=%b required z=00000001 stb=1", res, output_z_stb);
    end
    take_output();
  endtask

  initial begin
    test_reset();
    test_convert();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
